fc_argmax: RTL and testbench

- Classification stage directly downstream of the fully-connected layer.
- Consumes the FC layer's stable `outputNodes` vector once that layer raises `finished`.
- Scans the vector serially, one element per clock, and reports the index and value of the largest node.
- Uses the same level-`enable` / sticky-`finished` handshake as the other layer blocks, so it chains directly after the FC layer.

---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_argmax_cmp.sv | 22 ++
 rtl/fc_argmax.sv | 116 +++++++++++
 tb/tb_fc_argmax.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer family: data width and the
// common IDLE/SCAN/DONE controller state encoding.
package fc_pkg;

  // Node value width, shared with fc_layer so the two blocks chain directly
  localparam int DATA_WIDTH = 16;

  // Controller states reused by the layer blocks that follow the
  // level-enable / sticky-finished handshake
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } layerState_e;

endpackage : fc_pkg

// File: rtl/fc_argmax_cmp.sv
// Strict "a greater than b" comparator for the argmax scan.
// Build option: define FC_ARGMAX_SIGNED_EN to compare operands as
// two's-complement values; otherwise the comparison is unsigned magnitude.
// The macro is kept here so the controller is identical in both builds.
module fc_argmax_cmp
  import fc_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  greater
);

  // Strictly greater only, so equal values never displace the earlier index
  always_comb begin
`ifdef FC_ARGMAX_SIGNED_EN
    greater = ($signed(a) > $signed(b));
`else
    greater = (a > b);
`endif
  end

endmodule : fc_argmax_cmp

// File: rtl/fc_argmax.sv
// Argmax classification stage placed after the fully-connected layer.
// Scans inputNodes one element per clock once enable is raised and publishes
// the index and value of the largest node with a sticky finished flag.
// Build option: FC_ARGMAX_SIGNED_EN (handled inside fc_argmax_cmp) selects a
// signed comparison; the default build compares unsigned.
module fc_argmax
  import fc_pkg::*;
#(
  parameter int numNodes = 3,
  parameter int idxWidth = (numNodes > 1) ? $clog2(numNodes) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] inputNodes [0:numNodes-1],
  output logic [idxWidth-1:0]   classIndex,
  output logic [DATA_WIDTH-1:0] maxValue,
  output logic                  finished
);

  localparam logic [idxWidth-1:0] lastIdx = idxWidth'(numNodes - 1);
  localparam logic [idxWidth-1:0] oneIdx  = idxWidth'(1);

  layerState_e           state;
  logic [idxWidth-1:0]   idx;
  logic [idxWidth-1:0]   bestIdx;
  logic [DATA_WIDTH-1:0] best;

  logic [DATA_WIDTH-1:0] candidate;
  logic                  candGreater;
  logic [DATA_WIDTH-1:0] nextBest;
  logic [idxWidth-1:0]   nextBestIdx;

  // Node currently under inspection during the scan
  always_comb begin
    candidate = inputNodes[idx];
  end

  fc_argmax_cmp u_cmp (
    .a       (candidate),
    .b       (best),
    .greater (candGreater)
  );

  // Best-so-far after folding in the current candidate; ties keep the old one
  always_comb begin
    nextBest    = best;
    nextBestIdx = bestIdx;
    if (candGreater) begin
      nextBest    = candidate;
      nextBestIdx = idx;
    end
  end

  // Controller: seeds from node 0, scans the rest, then holds the result
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      bestIdx    <= '0;
      best       <= '0;
      classIndex <= '0;
      maxValue   <= '0;
      finished   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          finished <= 1'b0;
          if (enable) begin
            best    <= inputNodes[0];
            bestIdx <= '0;
            idx     <= oneIdx;
            if (numNodes == 1) begin
              classIndex <= '0;
              maxValue   <= inputNodes[0];
              finished   <= 1'b1;
              state      <= DONE;
            end else begin
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            best    <= nextBest;
            bestIdx <= nextBestIdx;
            if (idx == lastIdx) begin
              classIndex <= nextBestIdx;
              maxValue   <= nextBest;
              finished   <= 1'b1;
              state      <= DONE;
            end else begin
              idx <= idx + oneIdx;
            end
          end
        end

        DONE: begin
          if (!enable) begin
            finished <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          finished <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule : fc_argmax

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: stimulus pushes hand-computed results into
// a queue, and a monitor pops and compares whenever finished rises.
module tb_fc_argmax;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        enable1;
  logic [15:0] nodes  [0:2];
  logic [15:0] nodes1 [0:0];
  logic [1:0]  classIndex;
  logic [15:0] maxValue;
  logic        finished;
  logic [0:0]  classIndex1;
  logic [15:0] maxValue1;
  logic        finished1;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] val;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  logic prevFin;
  int   tests;
  int   fails;

  fc_argmax #(.numNodes(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .inputNodes (nodes),
    .classIndex (classIndex),
    .maxValue   (maxValue),
    .finished   (finished)
  );

  fc_argmax #(.numNodes(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable1),
    .inputNodes (nodes1),
    .classIndex (classIndex1),
    .maxValue   (maxValue1),
    .finished   (finished1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Counts edges until finished is seen, bounded, and checks the latency
  task automatic waitFinished(input int expEdges, input string name);
    int edges;
    edges = 0;
    while (edges < 10 && !finished) begin
      @(negedge clk);
      edges++;
    end
    checkOutput(name, edges, expEdges);
  endtask

  // One full scan: expect result, hold it, then drop enable and see finished clear
  task automatic applyStimulus(input logic [15:0] n0, input logic [15:0] n1,
                               input logic [15:0] n2, input logic [1:0] expIdx,
                               input logic [15:0] expVal, input string name);
    exp_t e;
    nodes[0] = n0;
    nodes[1] = n1;
    nodes[2] = n2;
    e.idx = expIdx;
    e.val = expVal;
    expQ.push_back(e);
    enable = 1'b1;
    waitFinished(3, {name, "_latency"});
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checkOutput({name, "_finishedClear"}, 32'(finished), 32'd0);
    checkOutput({name, "_maxKept"}, 32'(maxValue), 32'(expVal));
  endtask

  // Monitor: pop on a rising finished, check the held value while it stays high
  always @(negedge clk) begin
    if (finished && !prevFin) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedFinish", 32'(finished), 32'd0);
      end else begin
        lastExp = expQ.pop_front();
        checkOutput("classIndex", 32'(classIndex), 32'(lastExp.idx));
        checkOutput("maxValue", 32'(maxValue), 32'(lastExp.val));
      end
    end else if (finished && prevFin) begin
      checkOutput("holdIndex", 32'(classIndex), 32'(lastExp.idx));
      checkOutput("holdValue", 32'(maxValue), 32'(lastExp.val));
    end
    prevFin = finished;
  end

  initial begin
    exp_t e;
    tests   = 0;
    fails   = 0;
    prevFin = 1'b0;
    reset   = 1'b0;
    enable  = 1'b0;
    enable1 = 1'b0;
    nodes[0] = 16'd0; nodes[1] = 16'd0; nodes[2] = 16'd0;
    nodes1[0] = 16'd0;
    repeat (2) @(negedge clk);
    checkOutput("resetIndex", 32'(classIndex), 32'd0);
    checkOutput("resetValue", 32'(maxValue), 32'd0);
    checkOutput("resetFinished", 32'(finished), 32'd0);
    checkOutput("resetFinished1", 32'(finished1), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic, ties, sign
    applyStimulus(16'd5, 16'd9, 16'd2, 2'd1, 16'd9, "basic");
    applyStimulus(16'd7, 16'd7, 16'd3, 2'd0, 16'd7, "tieLow");
    applyStimulus(16'd3, 16'd7, 16'd7, 2'd1, 16'd7, "tieHigh");
`ifdef FC_ARGMAX_SIGNED_EN
    applyStimulus(16'h0001, 16'h8000, 16'h0000, 2'd0, 16'h0001, "sign");
`else
    applyStimulus(16'h0001, 16'h8000, 16'h0000, 2'd1, 16'h8000, "sign");
`endif

    // Abort: complete run, then drop enable after the second edge of a new one
    applyStimulus(16'd5, 16'd9, 16'd2, 2'd1, 16'd9, "preAbort");
    nodes[0] = 16'd1; nodes[1] = 16'd2; nodes[2] = 16'd8;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abortFinished", 32'(finished), 32'd0);
    checkOutput("abortIndex", 32'(classIndex), 32'd1);
    checkOutput("abortValue", 32'(maxValue), 32'd9);
    applyStimulus(16'd1, 16'd2, 16'd8, 2'd2, 16'd8, "afterAbort");

    // Reset on the second scan edge
    nodes[0] = 16'd4; nodes[1] = 16'd6; nodes[2] = 16'd1;
    enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midResetIndex", 32'(classIndex), 32'd0);
    checkOutput("midResetValue", 32'(maxValue), 32'd0);
    checkOutput("midResetFinished", 32'(finished), 32'd0);
    e.idx = 2'd1;
    e.val = 16'd6;
    expQ.push_back(e);
    reset = 1'b1;
    waitFinished(3, "afterMidReset_latency");
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Reset together with the first enable edge
    nodes[0] = 16'd2; nodes[1] = 16'd3; nodes[2] = 16'd9;
    enable = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    checkOutput("startResetFinished", 32'(finished), 32'd0);
    checkOutput("startResetValue", 32'(maxValue), 32'd0);
    e.idx = 2'd2;
    e.val = 16'd9;
    expQ.push_back(e);
    reset = 1'b1;
    waitFinished(3, "afterStartReset_latency");
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Single-node instance finishes on the first edge
    nodes1[0] = 16'h1234;
    enable1 = 1'b1;
    @(negedge clk);
    checkOutput("single_finished", 32'(finished1), 32'd1);
    checkOutput("single_index", 32'(classIndex1), 32'd0);
    checkOutput("single_value", 32'(maxValue1), 32'h1234);
    enable1 = 1'b0;
    @(negedge clk);
    checkOutput("single_finishedClear", 32'(finished1), 32'd0);
    nodes1[0] = 16'h00AB;
    enable1 = 1'b1;
    @(negedge clk);
    checkOutput("single2_value", 32'(maxValue1), 32'h00AB);
    enable1 = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fc_argmax
